// File: rtl/usb_pkt_fifo.sv
// rtl/usb_pkt_fifo.sv - single-clock packet FIFO feeding the USB slave-FIFO port
// Streams buffered words to the CPU and closes packets with PKTEND on marker+trailer or idle timeout.
module usb_pkt_fifo #(
  parameter int               WIDTH    = 8,
  parameter int               AW       = 14,
  parameter int               MINFREE  = 10,
  parameter logic [WIDTH-1:0] END_MARK = WIDTH'(8'hBF),
  parameter int               TRAILER  = 2,
  parameter int               IDLE_TO  = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             full,
  output logic             overflow,
  output logic [AW:0]      level,
  input  logic             flag,
  output logic [WIDTH-1:0] xdata,
  output logic             xwrite,
  output logic             xpkte
);

  localparam int DEPTH = 1 << AW;
  localparam int ICW = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;
  localparam logic [ICW-1:0] IDLE_LAST = ICW'((IDLE_TO > 0) ? IDLE_TO - 1 : 0);
  localparam logic [3:0] TRL = 4'(TRAILER);

  typedef enum logic {S_IDLE, S_TRAIL} state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wadr_q, radr_q;
  logic [AW:0]      level_q, level_d;
  logic [3:0]       tcnt_q;
  logic [ICW-1:0]   idle_q;
  logic             dirty_q, overflow_q, busy_q, full_q, xwrite_q, xpkte_q;
  logic [WIDTH-1:0] xdata_q;
  state_t           state_q;

  logic             wr_en, rd_en, end_pkt;
  logic [WIDTH-1:0] word;

  assign word = mem_q[radr_q];

  always_comb begin
    wr_en   = write & ~full_q;
    rd_en   = (level_q != '0) & ~flag;
    level_d = level_q;
    if (wr_en && !rd_en)      level_d = level_q + 1'b1;
    else if (!wr_en && rd_en) level_d = level_q - 1'b1;
    end_pkt = rd_en && (((state_q == S_IDLE) && (word == END_MARK) && (TRAILER == 0)) ||
                        ((state_q == S_TRAIL) && (tcnt_q == 4'd1)));
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wadr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wadr_q     <= '0;
      radr_q     <= '0;
      level_q    <= '0;
      tcnt_q     <= '0;
      idle_q     <= '0;
      dirty_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      xwrite_q   <= 1'b0;
      xdata_q    <= '0;
      xpkte_q    <= 1'b1;
      state_q    <= S_IDLE;
    end else begin
      level_q  <= level_d;
      busy_q   <= ({1'b0, level_d} + (AW+2)'(MINFREE)) > (AW+2)'(DEPTH);
      full_q   <= level_d == (AW+1)'(DEPTH);
      xwrite_q <= rd_en;
      xpkte_q  <= 1'b0;
      if (wr_en) wadr_q <= wadr_q + 1'b1;
      if (write && full_q) overflow_q <= 1'b1;
      if (rd_en) begin
        xdata_q <= word;
        radr_q  <= radr_q + 1'b1;
        idle_q  <= '0;
        xpkte_q <= end_pkt;
        dirty_q <= ~end_pkt;
        case (state_q)
          S_IDLE: begin
            if (word == END_MARK && TRAILER != 0) begin
              tcnt_q  <= TRL;
              state_q <= S_TRAIL;
            end
          end
          default: begin
            if (tcnt_q == 4'd1) state_q <= S_IDLE;
            else                tcnt_q  <= tcnt_q - 1'b1;
          end
        endcase
      end else if (IDLE_TO > 0 && dirty_q) begin
        // Counter saturates at the limit so a timeout held off by flag fires once flag drops.
        if (idle_q == IDLE_LAST) begin
          if (!flag) begin
            xpkte_q <= 1'b1;
            dirty_q <= 1'b0;
            idle_q  <= '0;
            state_q <= S_IDLE;
          end
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign full     = full_q;
  assign overflow = overflow_q;
  assign level    = level_q;
  assign xdata    = xdata_q;
  assign xwrite   = xwrite_q;
  assign xpkte    = xpkte_q;

endmodule

// File: tb/tb_usb_pkt_fifo.sv
// tb/tb_usb_pkt_fifo.sv - self-checking bench for usb_pkt_fifo
// Queue-based reference model, per-scenario tasks plus a randomized soak.
module tb_usb_pkt_fifo;

  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int MINFREE = 10;
  localparam int TRAILER = 2;
  localparam int IDLE_TO = 16;
  localparam logic [7:0] MARK = 8'hBF;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1, write_i = 1'b0, flag_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       busy_o, full_o, overflow_o, xwrite_o, xpkte_o;
  logic [AW:0] level_o;
  logic [7:0] xdata_o;

  usb_pkt_fifo #(.WIDTH(8), .AW(AW), .MINFREE(MINFREE), .END_MARK(MARK),
                 .TRAILER(TRAILER), .IDLE_TO(IDLE_TO)) dut (
    .clk(clk), .reset(reset_i), .write(write_i), .data(data_i),
    .busy(busy_o), .full(full_o), .overflow(overflow_o), .level(level_o),
    .flag(flag_i), .xdata(xdata_o), .xwrite(xwrite_o), .xpkte(xpkte_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_cycles = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0, m_xwrite = 1'b0, m_xpkte = 1'b1;
  logic [7:0] m_xdata = 8'h00;
  int         trail_left = 0, idle_cnt = 0;
  bit         dirty = 0;

  function automatic logic [17:0] expv();
    logic [AW:0] lv;
    lv = (AW+1)'(q.size());
    return {m_xwrite, m_xpkte, m_xdata, lv, (DEPTH - q.size()) < MINFREE,
            q.size() == DEPTH, m_ovf};
  endfunction

  function automatic logic [17:0] dutv();
    return {xwrite_o, xpkte_o, xdata_o, level_o, busy_o, full_o, overflow_o};
  endfunction

  // Drives one clock and advances the model: words leave in order, packets end
  // TRAILER words after a marker, or IDLE_TO silent cycles after unterminated output.
  task automatic cycle(input logic r, input logic w, input logic [7:0] d, input logic f);
    bit full_now, rd;
    reset_i = r; write_i = w; data_i = d; flag_i = f;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 0; m_xwrite = 0; m_xdata = 8'h00; m_xpkte = 1;
      trail_left = 0; idle_cnt = 0; dirty = 0;
    end else begin
      full_now = (q.size() == DEPTH);
      rd = (q.size() != 0) && !f;
      m_xpkte = 0;
      m_xwrite = rd;
      if (w && full_now) m_ovf = 1;
      if (rd) begin
        m_xdata = q.pop_front();
        idle_cnt = 0;
        if (trail_left == 0) begin
          if (m_xdata == MARK) begin
            if (TRAILER == 0) m_xpkte = 1;
            else trail_left = TRAILER;
          end
        end else begin
          trail_left--;
          if (trail_left == 0) m_xpkte = 1;
        end
        dirty = !m_xpkte;
      end else if (dirty) begin
        idle_cnt++;
        if (idle_cnt >= IDLE_TO && !f) begin
          m_xpkte = 1; dirty = 0; idle_cnt = 0; trail_left = 0;
        end
      end
      if (w && !full_now) q.push_back(d);
    end
    n_cycles++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 8'h00, 0);
      vectors++;
      if (dutv() !== expv() || xpkte_o !== 1'b1) begin
        miscompares++;
        $display("FAIL reset cyc %0d got=%h exp=%h xpkte=%b", n_cycles, dutv(), expv(), xpkte_o);
      end
    end
    cycle(0, 0, 8'h00, 0);
    vectors++;
    if (dutv() !== expv() || xpkte_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got=%h exp=%h", dutv(), expv());
    end
  endtask

  task automatic test_marker();
    logic [7:0] seq [5] = '{8'h01, 8'hBF, 8'h02, 8'h03, 8'h04};
    int pk_on_03 = 0, pk_total = 0, outs = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 5) cycle(0, 1, seq[i], 0);
      else       cycle(0, 0, 8'h00, 0);
      vectors++;
      if (dutv() !== expv()) begin
        miscompares++;
        $display("FAIL marker cyc %0d got=%h exp=%h", n_cycles, dutv(), expv());
      end
      if (xwrite_o) outs++;
      if (xpkte_o) pk_total++;
      if (xpkte_o && xwrite_o && xdata_o == 8'h03) pk_on_03++;
    end
    vectors++;
    if (outs != 5 || pk_total != 1 || pk_on_03 != 1 || level_o !== '0) begin
      miscompares++;
      $display("FAIL marker_summary got outs=%0d pk=%0d pk03=%0d level=%0d exp 5 1 1 0",
               outs, pk_total, pk_on_03, level_o);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 8'h00, 0);
      vectors++;
      if (dutv() !== expv()) begin
        miscompares++;
        $display("FAIL marker_drain cyc %0d got=%h exp=%h", n_cycles, dutv(), expv());
      end
    end
  endtask

  task automatic test_overflow();
    int outs = 0;
    bit order_ok = 1;
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 17; i++) begin
      cycle(0, 1, 8'(8'h40 + i), 1);
      vectors++;
      if (dutv() !== expv()) begin
        miscompares++;
        $display("FAIL overflow_fill cyc %0d got=%h exp=%h", n_cycles, dutv(), expv());
      end
      if (i == 6) begin
        vectors++;
        if (busy_o !== 1'b1 || full_o !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_at_7 got busy=%b full=%b exp 1 0", busy_o, full_o);
        end
      end
    end
    vectors++;
    if (full_o !== 1'b1 || overflow_o !== 1'b1 || level_o != (AW+1)'(16)) begin
      miscompares++;
      $display("FAIL overflow_state got full=%b ovf=%b level=%0d exp 1 1 16", full_o, overflow_o, level_o);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 8'h00, 0);
      vectors++;
      if (dutv() !== expv()) begin
        miscompares++;
        $display("FAIL overflow_drain cyc %0d got=%h exp=%h", n_cycles, dutv(), expv());
      end
      if (xwrite_o) begin
        if (xdata_o !== 8'(8'h40 + outs)) order_ok = 0;
        outs++;
      end
    end
    vectors++;
    if (outs != 16 || !order_ok) begin
      miscompares++;
      $display("FAIL overflow_count got outs=%0d order_ok=%0d exp 16 1", outs, order_ok);
    end
  endtask

  task automatic test_timeout();
    int pk = 0, pk_lat = -1, last_out = -1;
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 45; i++) begin
      if (i < 3) cycle(0, 1, 8'(8'h11 * (i + 1)), 0);
      else       cycle(0, 0, 8'h00, 0);
      vectors++;
      if (dutv() !== expv()) begin
        miscompares++;
        $display("FAIL timeout cyc %0d got=%h exp=%h", n_cycles, dutv(), expv());
      end
      if (xwrite_o) last_out = i;
      if (xpkte_o) begin
        pk++;
        if (!xwrite_o) pk_lat = i - last_out;
      end
    end
    vectors++;
    if (pk != 1 || pk_lat != IDLE_TO) begin
      miscompares++;
      $display("FAIL timeout_pulse got pulses=%0d latency=%0d exp 1 %0d", pk, pk_lat, IDLE_TO);
    end
  endtask

  task automatic test_stall();
    logic [AW:0] lv;
    int pk_word = 0;
    cycle(1, 0, 8'h00, 0);
    cycle(0, 1, MARK, 0);
    cycle(0, 1, 8'hA1, 0);
    cycle(0, 1, 8'hA2, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 8'h00, 1);
      vectors++;
      if (dutv() !== expv() || xwrite_o !== 1'b0) begin
        miscompares++;
        $display("FAIL stall cyc %0d got=%h exp=%h", n_cycles, dutv(), expv());
      end
    end
    lv = level_o;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 8'(8'hC0 + i), 0);
      vectors++;
      if (dutv() !== expv() || level_o !== lv) begin
        miscompares++;
        $display("FAIL stall_resume cyc %0d got=%h exp=%h level=%0d", n_cycles, dutv(), expv(), lv);
      end
      if (xpkte_o && xwrite_o && xdata_o == 8'hA2) pk_word++;
    end
    vectors++;
    if (pk_word != 1) begin
      miscompares++;
      $display("FAIL stall_pkte got=%0d exp 1", pk_word);
    end
  endtask

  task automatic test_random();
    int wp, fp;
    logic [7:0] d;
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) begin
        wp = $urandom_range(10, 90);
        fp = $urandom_range(0, 70);
      end
      d = ($urandom_range(0, 5) == 0) ? MARK : 8'($urandom);
      cycle(0, ($urandom_range(0, 99) < wp), d, ($urandom_range(0, 99) < fp));
      vectors++;
      if (dutv() !== expv()) begin
        miscompares++;
        $display("FAIL random cyc %0d got=%h exp=%h", n_cycles, dutv(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_marker();
    test_overflow();
    test_timeout();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
